min_sec_timebase: RTL and testbench

Free-running time base for the 12-hour clock datapath. Divides the board clock down to a one-second tick and counts seconds and minutes as BCD digit pairs, each from 00 to 59. Sits directly upstream of the hours-digit counter and drives its enable with a single-cycle pulse at each 59:59 -> 00:00 rollover. Also feeds the four minute and second digits to the display stage.

---
 rtl/timebase_pkg.sv | 21 ++
 rtl/min_sec_timebase_bcd_mod60.sv | 38 +++
 rtl/min_sec_timebase.sv | 102 ++++++++++
 tb/tb_min_sec_timebase.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/timebase_pkg.sv
// Shared types and constants for the minute/second time base.
package timebase_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_MAX_TENS = 4'd5;
    localparam bcd_t MAX_ONES     = 4'd9;

    typedef struct packed {
        bcd_t min_tens;
        bcd_t min_ones;
        bcd_t sec_tens;
        bcd_t sec_ones;
    } mmss_t;

    // True when a tens/ones pair reads 59.
    function automatic logic at_59(input bcd_t tens, input bcd_t ones);
        return (tens == SEC_MAX_TENS) && (ones == MAX_ONES);
    endfunction

endpackage

// File: rtl/min_sec_timebase_bcd_mod60.sv
// Two-digit BCD counter, 00..59. clr has priority over inc.
// wrap flags the increment that takes 59 back to 00.
module bcd_mod60
    import timebase_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output bcd_t ones,
    output bcd_t tens,
    output logic wrap
);

    // Carry out on the 59 -> 00 increment.
    always_comb begin
        wrap = inc && at_59(tens, ones);
    end

    // Digit registers with BCD rollover of ones into tens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones <= '0;
            tens <= '0;
        end else if (clr) begin
            ones <= '0;
            tens <= '0;
        end else if (inc) begin
            if (ones == MAX_ONES) begin
                ones <= '0;
                tens <= (tens == SEC_MAX_TENS) ? '0 : tens + 4'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/min_sec_timebase.sv
// Minute/second time base: prescaler to a one-second tick, BCD seconds
// and minutes, and a one-cycle hour-advance pulse at 59:59 -> 00:00.
// Build option TIME_SET_EN adds the min_adv/hr_adv manual set inputs.
module min_sec_timebase
    import timebase_pkg::*;
#(
    parameter int unsigned CLK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
`ifdef TIME_SET_EN
    input  logic       min_adv,
    input  logic       hr_adv,
`endif
    output logic       tick,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       hr_enb
);

    localparam int unsigned      PS_W   = $clog2(CLK_DIV);
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLK_DIV - 1);

    logic [PS_W-1:0] ps;
    logic            min_set;
    logic            hr_set;
    logic            sec_wrap;
    logic            min_wrap;
    logic            min_inc;
    mmss_t           t;

`ifdef TIME_SET_EN
    // [1:0] synchronize, [2] holds the previous synchronized level.
    logic [2:0] min_sync;
    logic [2:0] hr_sync;

    // Synchronizer and edge-history flops for the set buttons.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_sync <= '0;
            hr_sync  <= '0;
        end else begin
            min_sync <= {min_sync[1:0], min_adv};
            hr_sync  <= {hr_sync[1:0], hr_adv};
        end
    end

    assign min_set = min_sync[1] & ~min_sync[2];
    assign hr_set  = hr_sync[1]  & ~hr_sync[2];
`else
    assign min_set = 1'b0;
    assign hr_set  = 1'b0;
`endif

    // A minute-set edge swallows any tick landing in the same cycle.
    always_comb begin
        tick    = run && (ps == PS_MAX) && !min_set;
        min_inc = sec_wrap | min_set;
        // Rollover wrap only; a set-driven 59 -> 00 must not advance hours.
        hr_enb  = (min_wrap && !min_set) || hr_set;
    end

    // Prescaler: free-runs while run is high, cleared by a minute set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps <= '0;
        end else if (min_set) begin
            ps <= '0;
        end else if (run) begin
            ps <= (ps == PS_MAX) ? '0 : ps + PS_W'(1);
        end
    end

    bcd_mod60 u_sec (
        .clk  (clk),
        .rst  (rst),
        .inc  (tick),
        .clr  (min_set),
        .ones (t.sec_ones),
        .tens (t.sec_tens),
        .wrap (sec_wrap)
    );

    bcd_mod60 u_min (
        .clk  (clk),
        .rst  (rst),
        .inc  (min_inc),
        .clr  (1'b0),
        .ones (t.min_ones),
        .tens (t.min_tens),
        .wrap (min_wrap)
    );

    assign sec_ones = t.sec_ones;
    assign sec_tens = t.sec_tens;
    assign min_ones = t.min_ones;
    assign min_tens = t.min_tens;

endmodule

// File: tb/tb_min_sec_timebase.sv
// Self-checking bench for min_sec_timebase with CLK_DIV = 4.
// Define TIME_SET_EN for both RTL and bench to exercise the set inputs.
module tb_min_sec_timebase;

    localparam int DIV = 4;

    logic       clk;
    logic       rst;
    logic       run;
    logic       min_adv;
    logic       hr_adv;
    logic       tick;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       hr_enb;

    int n_cmp = 0;
    int n_err = 0;
    int ps_m;
    int secs_m;
    int hr_pulses = 0;
    logic hr_prev = 1'b0;

    min_sec_timebase #(.CLK_DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
`ifdef TIME_SET_EN
        .min_adv  (min_adv),
        .hr_adv   (hr_adv),
`endif
        .tick     (tick),
        .sec_ones (sec_ones),
        .sec_tens (sec_tens),
        .min_ones (min_ones),
        .min_tens (min_tens),
        .hr_enb   (hr_enb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic run;
        logic tick;
        int   secs;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int bcd_of(input int s);
        int mm;
        int ss;
        mm = s / 60;
        ss = s % 60;
        return ((mm / 10) << 12) | ((mm % 10) << 8) | ((ss / 10) << 4) | (ss % 10);
    endfunction

    function automatic int digits();
        return {16'h0, min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    function automatic void add(input logic r, input logic t, input int s);
        vec_t v;
        v.run  = r;
        v.tick = t;
        v.secs = s;
        vecs.push_back(v);
    endfunction

    // One clock with run=1, checked against the integer model.
    task automatic cycle();
        logic et;
        @(negedge clk);
        et = (ps_m == DIV - 1);
        chk("run_tick", int'(tick), int'(et));
        chk("run_hr_enb", int'(hr_enb), int'(et && secs_m == 3599));
        chk("run_digits", digits(), bcd_of(secs_m));
        if (hr_enb) hr_pulses++;
        if (hr_enb && hr_prev) chk("hr_enb_width", 2, 1);
        hr_prev = hr_enb;
        @(posedge clk);
        #1;
        if (ps_m == DIV - 1) begin
            ps_m   = 0;
            secs_m = (secs_m + 1) % 3600;
        end else begin
            ps_m++;
        end
    endtask

    task automatic run_to(input int s, input string name);
        int guard;
        guard = 0;
        while (!(secs_m == s && ps_m == DIV - 1) && guard < 20000) begin
            cycle();
            guard++;
        end
        if (guard >= 20000) chk({name, "_timeout"}, guard, 0);
    endtask

    initial begin
        rst     = 1'b0;
        run     = 1'b0;
        min_adv = 1'b0;
        hr_adv  = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("reset_digits", digits(), 0);
        chk("reset_tick", int'(tick), 0);
        chk("reset_hr_enb", int'(hr_enb), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Cycle-by-cycle table starting in cycle 1 after reset release.
        add(1, 0, 0); add(1, 0, 0); add(1, 0, 0); add(1, 1, 0);
        add(1, 0, 1); add(1, 0, 1); add(1, 0, 1); add(1, 1, 1);
        add(1, 0, 2); add(1, 0, 2);
        for (int i = 0; i < 10; i++) add(0, 0, 2);
        add(1, 0, 2); add(1, 1, 2);
        add(1, 0, 3); add(1, 0, 3); add(1, 0, 3); add(1, 1, 3);
        add(1, 0, 4); add(1, 0, 4); add(1, 0, 4);
        add(0, 0, 4); add(0, 0, 4);
        add(1, 1, 4);
        add(1, 0, 5);

        foreach (vecs[i]) begin
            run = vecs[i].run;
            @(negedge clk);
            chk($sformatf("vec%0d_tick", i + 1), int'(tick), int'(vecs[i].tick));
            chk($sformatf("vec%0d_digits", i + 1), digits(), bcd_of(vecs[i].secs));
            chk($sformatf("vec%0d_hr_enb", i + 1), int'(hr_enb), 0);
            @(posedge clk);
            #1;
        end

        // Last table row was prescaler 0 at 00:05.
        run    = 1'b1;
        ps_m   = 1;
        secs_m = 5;

        run_to(59, "to_0059");
        chk("tick_0059", int'(tick), 1);
        chk("hr_enb_0059", int'(hr_enb), 0);
        cycle();
        chk("digits_0100", digits(), 16'h0100);

        run_to(3599, "to_5959");
        chk("hr_enb_5959", int'(hr_enb), 1);
        cycle();
        chk("hr_enb_after", int'(hr_enb), 0);
        chk("digits_0000", digits(), 16'h0000);
        chk("hr_pulse_count", hr_pulses, 1);

        // Asynchronous reset at 12:34 with the prescaler at its last count.
        run_to(754, "to_1234");
        chk("pre_rst_tick", int'(tick), 1);
        chk("pre_rst_digits", digits(), 16'h1234);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_digits", digits(), 0);
        chk("async_rst_tick", int'(tick), 0);
        chk("async_rst_hr_enb", int'(hr_enb), 0);
        run = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

`ifdef TIME_SET_EN
        // 59 minute presses with run low -> 59:00, prescaler cleared.
        for (int p = 0; p < 59; p++) begin
            min_adv = 1'b1;
            repeat (4) @(posedge clk);
            #1 min_adv = 1'b0;
            repeat (4) @(posedge clk);
            #1;
        end
        chk("set_5900", digits(), 16'h5900);
        run = 1'b1;
        repeat (30 * DIV) @(posedge clk);
        #1 run = 1'b0;
        chk("set_5930", digits(), 16'h5930);

        min_adv = 1'b1;
        @(posedge clk); #1;
        chk("madv_e1_hr", int'(hr_enb), 0);
        @(posedge clk); #1;
        chk("madv_e2_digits", digits(), 16'h5930);
        chk("madv_e2_hr", int'(hr_enb), 0);
        @(posedge clk); #1;
        chk("madv_e3_digits", digits(), 16'h0000);
        chk("madv_e3_hr", int'(hr_enb), 0);
        min_adv = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        hr_adv = 1'b1;
        @(posedge clk); #1;
        chk("hadv_e1_hr", int'(hr_enb), 0);
        @(posedge clk); #1;
        chk("hadv_e2_hr", int'(hr_enb), 1);
        @(posedge clk); #1;
        chk("hadv_e3_hr", int'(hr_enb), 0);
        chk("hadv_digits", digits(), 16'h0000);
        hr_adv = 1'b0;
        @(posedge clk); #1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
